eth_tx_arbiter: RTL and testbench

- Shares the single MAC transmit byte interface (vld/dat/sof/eof/ack) between N_PORTS frame sources.
- Sits between the protocol engines (ARP, ICMP, UDP, etc.) and the eth_mac TX port, in the clk_mac domain.
- Arbitration is frame-granular round-robin: once granted, a port owns the MAC until its eof byte is accepted.
- Stray beats outside a frame are acked and discarded so that a misbehaving source cannot wedge the MAC.

---
 rtl/eth_tx_arbiter.sv | 99 +++++++++
 tb/tb_eth_tx_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-granular round-robin sharing of one MAC TX byte port among N_PORTS sources.
// Beats arriving without sof while idle are acked and counted so a bad source cannot stall the MAC.
module eth_tx_arbiter #(
   parameter int N_PORTS = 4,
   localparam int IDW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic                 clk_mac,
   input  logic                 rst_n,
   input  logic [N_PORTS-1:0]   req_vld,
   input  logic [8*N_PORTS-1:0] req_dat,
   input  logic [N_PORTS-1:0]   req_sof,
   input  logic [N_PORTS-1:0]   req_eof,
   output logic [N_PORTS-1:0]   req_ack,
   output logic                 tx_vld,
   output logic [7:0]           tx_dat,
   output logic                 tx_sof,
   output logic                 tx_eof,
   input  logic                 tx_ack,
   output logic [IDW-1:0]       grant_id,
   output logic                 busy,
   output logic                 frame_done,
   output logic [15:0]          drop_cnt
);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t                 r_state;
   logic [IDW-1:0]         r_rr;
   logic [IDW-1:0]         r_grant;
   logic                   r_busy;
   logic                   r_done;
   logic [15:0]            r_drop;
   logic                   w_active;
   logic [N_PORTS-1:0]     w_cand;
   logic [N_PORTS-1:0]     w_stray;
   logic [2*N_PORTS-1:0]   w_dbl;
   logic [IDW-1:0]         w_off;
   logic                   w_found;
   logic [IDW:0]           w_sum;
   logic [IDW-1:0]         w_pick;
   logic [3:0]             w_nstray;
   logic [16:0]            w_dsum;
   logic                   w_eof_hs;
   logic [IDW-1:0]         w_rr_nxt;
   assign w_active = (r_state == ACTIVE);
   assign w_cand   = req_vld & req_sof;
   assign w_stray  = req_vld & ~req_sof;
   assign tx_vld   = w_active & req_vld[r_grant];
   assign tx_sof   = w_active & req_sof[r_grant];
   assign tx_eof   = w_active & req_eof[r_grant];
   assign tx_dat   = w_active ? req_dat[{r_grant, 3'b000} +: 8] : 8'h00;
   assign req_ack  = w_active ? ({{(N_PORTS-1){1'b0}}, tx_ack} << r_grant) : (rst_n ? w_stray : '0);
   assign w_eof_hs = tx_vld & tx_ack & tx_eof;
   assign w_rr_nxt = (r_grant == IDW'(N_PORTS-1)) ? '0 : r_grant + 1'b1;
   assign grant_id   = r_grant;
   assign busy       = r_busy;
   assign frame_done = r_done;
   assign drop_cnt   = r_drop;
   // Rotating the doubled candidate vector by rr turns the wrapped search into a plain lowest-bit pick.
   always_comb begin
      w_dbl   = {w_cand, w_cand} >> r_rr;
      w_off   = '0;
      w_found = 1'b0;
      for (int i = N_PORTS-1; i >= 0; i--) begin
         if (w_dbl[i]) begin
            w_off   = IDW'(i);
            w_found = 1'b1;
         end
      end
      w_sum    = {1'b0, r_rr} + {1'b0, w_off};
      w_pick   = (w_sum >= (IDW+1)'(N_PORTS)) ? IDW'(w_sum - (IDW+1)'(N_PORTS)) : IDW'(w_sum);
      w_nstray = '0;
      for (int i = 0; i < N_PORTS; i++) w_nstray = w_nstray + {3'b000, w_stray[i]};
      w_dsum   = {1'b0, r_drop} + {13'd0, w_nstray};
   end
   always_ff @(posedge clk_mac) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_rr    <= '0;
         r_grant <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_drop  <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_state == IDLE) begin
            r_drop <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
            if (w_found) begin
               r_grant <= w_pick;
               r_state <= ACTIVE;
               r_busy  <= 1'b1;
            end
         end else if (w_eof_hs) begin
            r_rr    <= w_rr_nxt;
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed scoreboard bench for eth_tx_arbiter with four ports.
module tb_eth_tx_arbiter;
   localparam int N = 4;
   logic           clk_mac = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_vld = '0;
   logic [N-1:0]   req_sof = '0;
   logic [N-1:0]   req_eof = '0;
   logic [8*N-1:0] req_dat = '0;
   logic [N-1:0]   req_ack;
   logic           tx_vld;
   logic [7:0]     tx_dat;
   logic           tx_sof;
   logic           tx_eof;
   logic           tx_ack = 1'b0;
   logic [1:0]     grant_id;
   logic           busy;
   logic           frame_done;
   logic [15:0]    drop_cnt;
   int             n_tests = 0;
   int             n_fail = 0;
   logic [9:0]     src_q[N][$];
   logic [11:0]    sb[$];
   int             gap_q[$];
   logic [N-1:0]   acked = '0;
   logic           stray_all = 1'b0;
   logic           prev_eof = 1'b0;
   int             mon_beats = 0;
   int             fd_cnt = 0;
   int             cyc = 0;
   int             last_eof = -1;

   always #5 clk_mac = ~clk_mac;

   eth_tx_arbiter #(.N_PORTS(N)) dut (
      .clk_mac(clk_mac), .rst_n(rst_n),
      .req_vld(req_vld), .req_dat(req_dat), .req_sof(req_sof), .req_eof(req_eof), .req_ack(req_ack),
      .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_ack(tx_ack),
      .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_mac);
      #1;
   endtask

   task automatic step();
      @(posedge clk_mac);
      #1;
   endtask

   task automatic send_frame(input int p, input int n, input logic [7:0] b0);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = b0 + 8'(17 * i);
         src_q[p].push_back({i == 0, i == n-1, d});
         sb.push_back({2'(p), i == 0, i == n-1, d});
      end
   endtask

   task automatic stray(input int p, input int n);
      for (int i = 0; i < n; i++) src_q[p].push_back({2'b00, 8'(8'hE0 + i)});
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (sb.size() > 0 && k < budget) begin
         tick();
         k++;
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic chk_gaps(input int n);
      chk("gap_count", gap_q.size(), n);
      foreach (gap_q[i]) chk("frame_gap", gap_q[i], 2);
   endtask

   // Source models: present the queue head, retire it once the arbiter acked it.
   initial forever begin
      @(posedge clk_mac);
      #2;
      for (int p = 0; p < N; p++) begin
         if (acked[p] && src_q[p].size() > 0) src_q[p].delete(0);
         acked[p] = 1'b0;
         if (stray_all) begin
            req_vld[p] = 1'b1;
            req_sof[p] = 1'b0;
            req_eof[p] = 1'b0;
            req_dat[8*p +: 8] = 8'(p);
         end else if (src_q[p].size() > 0) begin
            req_vld[p] = 1'b1;
            {req_sof[p], req_eof[p], req_dat[8*p +: 8]} = src_q[p][0];
         end else begin
            req_vld[p] = 1'b0;
            req_sof[p] = 1'b0;
            req_eof[p] = 1'b0;
            req_dat[8*p +: 8] = 8'h00;
         end
      end
   end

   // MAC-side monitor: scoreboard pop, ack mirroring, frame_done timing and inter-frame gaps.
   initial forever begin
      logic [11:0] e;
      @(negedge clk_mac);
      cyc++;
      acked = req_vld & req_ack;
      chk("frame_done", frame_done, prev_eof);
      if (frame_done) fd_cnt++;
      prev_eof = rst_n && tx_vld && tx_ack && tx_eof;
      if (busy && sb.size() > 0) chk("req_ack", req_ack, tx_ack ? (4'b0001 << sb[0][11:10]) : 4'b0000);
      if (rst_n && tx_vld && tx_ack) begin
         mon_beats++;
         if (sb.size() == 0) chk("extra_beat", sb.size(), 1);
         else begin
            e = sb.pop_front();
            chk("beat", {grant_id, tx_sof, tx_eof, tx_dat}, e);
         end
         if (tx_sof && last_eof >= 0) gap_q.push_back(cyc - last_eof);
         if (tx_eof) last_eof = cyc;
      end
   end

   initial begin
      int k;
      int base;
      repeat (3) step();
      tick();
      chk("rst_tx_vld", tx_vld, 0);
      chk("rst_tx_sof", tx_sof, 0);
      chk("rst_tx_eof", tx_eof, 0);
      chk("rst_tx_dat", tx_dat, 0);
      chk("rst_req_ack", req_ack, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_cnt, 0);
      step();
      rst_n = 1'b1;
      tx_ack = 1'b1;
      send_frame(0, 2, 8'h01);
      send_frame(1, 2, 8'h11);
      send_frame(3, 2, 8'h31);
      tick();
      chk("sof_not_acked", req_ack, 0);
      chk("idle_tx_vld", tx_vld, 0);
      wait_done(40);
      tick();
      chk("cont_frames", fd_cnt, 3);
      chk("cont_busy", busy, 0);
      chk_gaps(2);
      step();
      gap_q.delete();
      last_eof = -1;
      send_frame(0, 2, 8'h40);
      send_frame(1, 2, 8'h50);
      send_frame(0, 2, 8'h60);
      send_frame(1, 2, 8'h70);
      wait_done(60);
      tick();
      chk_gaps(3);
      step();
      base = fd_cnt;
      send_frame(2, 3, 8'hAA);
      tick();
      chk("single_lat0_vld", tx_vld, 0);
      chk("single_lat0_busy", busy, 0);
      tick();
      chk("single_lat1_vld", tx_vld, 1);
      chk("single_busy", busy, 1);
      chk("single_grant", grant_id, 2);
      wait_done(20);
      tick();
      chk("single_done_cnt", fd_cnt - base, 1);
      chk("single_busy_end", busy, 0);
      chk("single_grant_hold", grant_id, 2);
      step();
      send_frame(1, 4, 8'h0F);
      k = 0;
      while (sb.size() > 0 && k < 40) begin
         step();
         tx_ack = ~tx_ack;
         k++;
      end
      chk("bp_drain", sb.size(), 0);
      tx_ack = 1'b1;
      tick();
      chk("bp_grant", grant_id, 1);
      chk("bp_busy_end", busy, 0);
      step();
      chk("stray_pre_drop", drop_cnt, 0);
      stray(0, 3);
      stray(3, 3);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stray_ack", req_ack, 4'b1001);
         chk("stray_idle", busy, 0);
      end
      tick();
      chk("stray_drop", drop_cnt, 6);
      chk("stray_ack_end", req_ack, 0);
      step();
      base = mon_beats;
      send_frame(2, 5, 8'h10);
      k = 0;
      while (mon_beats < base + 2 && k < 20) begin
         tick();
         k++;
      end
      chk("pre_reset_beats", mon_beats, base + 2);
      step();
      rst_n = 1'b0;
      tx_ack = 1'b0;
      src_q[2].delete();
      sb.delete();
      acked = '0;
      tick();
      tick();
      chk("mid_rst_tx_vld", tx_vld, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_drop", drop_cnt, 0);
      chk("mid_rst_grant", grant_id, 0);
      step();
      rst_n = 1'b1;
      tx_ack = 1'b1;
      send_frame(1, 2, 8'h5A);
      tick();
      tick();
      chk("post_rst_busy", busy, 1);
      chk("post_rst_grant", grant_id, 1);
      wait_done(20);
      tick();
      chk("post_rst_idle", busy, 0);
      step();
      stray_all = 1'b1;
      repeat (16383) @(posedge clk_mac);
      tick();
      chk("sat_ack_all", req_ack, 4'b1111);
      chk("sat_near", drop_cnt, 16'd65532);
      @(posedge clk_mac);
      tick();
      chk("sat_clip", drop_cnt, 16'hFFFF);
      @(posedge clk_mac);
      tick();
      chk("sat_hold", drop_cnt, 16'hFFFF);
      chk("sat_idle", busy, 0);
      step();
      stray_all = 1'b0;
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
